// File: rtl/data_sram_rsp_pkg.sv
// -----------------------------------------------------------------------------
// data_sram_rsp_pkg
// Definitions shared by the load/store unit and the data SRAM responder:
// load/store op encodings, byte-enable patterns and the read-pipeline
// control record.
// -----------------------------------------------------------------------------
package data_sram_rsp_pkg;

  // One-hot load op, bit 5 down to 0: {ld_b, ld_h, ld_w, ld_bu, ld_hu, ll_w}
  localparam int LOAD_OP_W = 6;
  localparam int LD_B      = 5;
  localparam int LD_H      = 4;
  localparam int LD_W      = 3;
  localparam int LD_BU     = 2;
  localparam int LD_HU     = 1;
  localparam int LL_W      = 0;

  // One-hot store op: {st_b, st_h, st_w}
  localparam int STORE_OP_W = 3;
  localparam int ST_B       = 2;
  localparam int ST_H       = 1;
  localparam int ST_W       = 0;

  // Byte-enable patterns for lane 0; shifted left by the byte offset.
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Byte enables for a store of the given op at byte offset 'off'.
  function automatic logic [3:0] store_be(input logic [STORE_OP_W-1:0] op,
                                          input logic [1:0]            off);
    logic [3:0] be;
    be = 4'b0000;
    if (op[ST_B])      be = BE_BYTE << off;
    else if (op[ST_H]) be = BE_HALF << {off[1], 1'b0};
    else if (op[ST_W]) be = BE_WORD;
    return be;
  endfunction

  // Control carried alongside the read data through each pipeline stage.
  typedef struct packed {
    logic                 valid;
    logic [4:0]           dest;
    logic [LOAD_OP_W-1:0] load_op;
    logic [1:0]           off;
  } rd_ctl_t;

endpackage

// File: rtl/data_sram_rsp_if.sv
// -----------------------------------------------------------------------------
// data_sram_rsp_if
// Request/response bundle between the load/store unit (master) and the data
// SRAM responder (slave).
//   request : data_sram_en/we/addr/wdata, req_load_op, req_dest, flush
//   response: rsp_valid, rsp_dest, rsp_rdata, rsp_load_result, rsp_ale, rsp_ll
// -----------------------------------------------------------------------------
interface data_sram_rsp_if;
  import data_sram_rsp_pkg::*;

  logic                 data_sram_en;
  logic [3:0]           data_sram_we;
  logic [31:0]          data_sram_addr;
  logic [31:0]          data_sram_wdata;
  logic [LOAD_OP_W-1:0] req_load_op;
  logic [4:0]           req_dest;
  logic                 flush;

  logic                 rsp_valid;
  logic [4:0]           rsp_dest;
  logic [31:0]          rsp_rdata;
  logic [31:0]          rsp_load_result;
  logic                 rsp_ale;
  logic                 rsp_ll;

  modport master (
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
           req_load_op, req_dest, flush,
    input  rsp_valid, rsp_dest, rsp_rdata, rsp_load_result, rsp_ale, rsp_ll
  );

  modport slave (
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
           req_load_op, req_dest, flush,
    output rsp_valid, rsp_dest, rsp_rdata, rsp_load_result, rsp_ale, rsp_ll
  );

endinterface

// File: rtl/data_sram_rsp_load_align.sv
// -----------------------------------------------------------------------------
// data_sram_rsp_load_align
// Combinational load formatter: selects the byte/half/word addressed by
// addr_lo_i out of a 32-bit RAM word and sign- or zero-extends it.
// Misaligned half/word loads flag ale_o and return zero.
//   word_i    : raw 32-bit word
//   addr_lo_i : byte address bits [1:0]
//   load_op_i : one-hot load op
//   result_o  : aligned, extended load value
//   ale_o     : address misaligned for this op
// -----------------------------------------------------------------------------
module data_sram_rsp_load_align
  import data_sram_rsp_pkg::*;
(
  input  logic [31:0]          word_i,
  input  logic [1:0]           addr_lo_i,
  input  logic [LOAD_OP_W-1:0] load_op_i,
  output logic [31:0]          result_o,
  output logic                 ale_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output of a combinational block gets a value on every path
  // (here via the default at the top); a missing assignment infers a latch.
  always_comb begin
    byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    ale_o    = ((load_op_i[LD_H] | load_op_i[LD_HU]) & addr_lo_i[0])
             | ((load_op_i[LD_W] | load_op_i[LL_W])  & (addr_lo_i != 2'b00));
    result_o = '0;
    if (!ale_o) begin
      if (load_op_i[LD_B])                      result_o = {{24{byte_sel[7]}}, byte_sel};
      else if (load_op_i[LD_BU])                result_o = {24'h0, byte_sel};
      else if (load_op_i[LD_H])                 result_o = {{16{half_sel[15]}}, half_sel};
      else if (load_op_i[LD_HU])                result_o = {16'h0, half_sel};
      else if (load_op_i[LD_W] | load_op_i[LL_W]) result_o = word_i;
    end
  end

endmodule

// File: rtl/data_sram_rsp.sv
// -----------------------------------------------------------------------------
// data_sram_rsp
// Data SRAM responder: word-organised RAM with byte write enables that answers
// loads after RD_LAT clock edges with the result already aligned/extended.
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset (pipeline/outputs only, not RAM)
//   bus    : data_sram_rsp_if.slave request/response bundle
// Parameters: ADDR_W word-index width, RD_LAT read latency (1 or 2),
//             INIT_FILE optional hex image for the RAM.
// -----------------------------------------------------------------------------
module data_sram_rsp
  import data_sram_rsp_pkg::*;
#(
  parameter int    ADDR_W    = 10,
  parameter int    RD_LAT    = 1,
  parameter string INIT_FILE = ""
) (
  input  logic           clk,
  input  logic           resetn,
  data_sram_rsp_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              wr_fire;
  logic              rd_fire;
  logic [31:0]       s1_word_q;
  rd_ctl_t           s1_ctl_d, s1_ctl_q;
  rd_ctl_t           last_ctl;
  logic [31:0]       last_word;
  logic [31:0]       align_result;
  logic              align_ale;
  logic              unused_addr_hi;

  // Upper address bits alias modulo the depth.
  assign idx            = bus.data_sram_addr[ADDR_W+1:2];
  assign unused_addr_hi = &{1'b0, bus.data_sram_addr[31:ADDR_W+2]};

  // A write wins over a load presented in the same cycle; flush and reset
  // suppress both.
  assign wr_fire = resetn & bus.data_sram_en & (|bus.data_sram_we) & ~bus.flush;
  assign rd_fire = resetn & bus.data_sram_en & ~(|bus.data_sram_we)
                 & (|bus.req_load_op) & ~bus.flush;

  // NOTE: the RAM array and data registers are deliberately not reset, so the
  // contents survive reset and the array maps onto block RAM; only the valid/
  // control path below is reset. Sequential state always uses <=.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_fire && bus.data_sram_we[b]) mem_q[idx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
    end
    if (rd_fire) s1_word_q <= mem_q[idx];
  end

  always_comb begin
    s1_ctl_d         = '0;
    s1_ctl_d.valid   = rd_fire;
    s1_ctl_d.dest    = bus.req_dest;
    s1_ctl_d.load_op = bus.req_load_op;
    s1_ctl_d.off     = bus.data_sram_addr[1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) s1_ctl_q <= '0;
    else         s1_ctl_q <= s1_ctl_d;
  end

  if (RD_LAT == 2) begin : g_lat2
    rd_ctl_t     s2_ctl_d, s2_ctl_q;
    logic [31:0] s2_word_q;

    // Flush kills the load sitting in stage 1.
    always_comb begin
      s2_ctl_d       = s1_ctl_q;
      s2_ctl_d.valid = s1_ctl_q.valid & ~bus.flush;
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) s2_ctl_q <= '0;
      else         s2_ctl_q <= s2_ctl_d;
    end

    always_ff @(posedge clk) begin
      if (s1_ctl_q.valid) s2_word_q <= s1_word_q;
    end

    assign last_ctl  = s2_ctl_q;
    assign last_word = s2_word_q;
  end else begin : g_lat1
    assign last_ctl  = s1_ctl_q;
    assign last_word = s1_word_q;
  end

  data_sram_rsp_load_align u_load_align (
    .word_i    (last_word),
    .addr_lo_i (last_ctl.off),
    .load_op_i (last_ctl.load_op),
    .result_o  (align_result),
    .ale_o     (align_ale)
  );

  // Everything is forced to zero when no response is presented, which also
  // makes reset clear the outputs immediately.
  assign bus.rsp_valid       = last_ctl.valid;
  assign bus.rsp_dest        = last_ctl.valid ? last_ctl.dest : 5'd0;
  assign bus.rsp_rdata       = last_ctl.valid ? last_word : 32'd0;
  assign bus.rsp_load_result = last_ctl.valid ? align_result : 32'd0;
  assign bus.rsp_ale         = last_ctl.valid & align_ale;
  assign bus.rsp_ll          = last_ctl.valid & last_ctl.load_op[LL_W];

endmodule

// File: tb/tb_data_sram_rsp.sv
// -----------------------------------------------------------------------------
// tb_data_sram_rsp
// Drives two responders (RD_LAT=1 and RD_LAT=2) with the same request stream.
// Loads push expected responses into one queue per DUT; a negedge monitor
// pops and compares them, including the cycle on which they appear.
// -----------------------------------------------------------------------------
module tb_data_sram_rsp;

  localparam logic [5:0] OP_NONE = 6'b000000;
  localparam logic [5:0] OP_LDB  = 6'b100000;
  localparam logic [5:0] OP_LDH  = 6'b010000;
  localparam logic [5:0] OP_LDW  = 6'b001000;
  localparam logic [5:0] OP_LDBU = 6'b000100;
  localparam logic [5:0] OP_LDHU = 6'b000010;
  localparam logic [5:0] OP_LLW  = 6'b000001;

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [5:0]  op;
    logic [4:0]  dest;
    logic [31:0] word;
    logic [31:0] res;
    logic        ale;
  } vec_t;

  typedef struct {
    int          due;
    logic [4:0]  dest;
    logic [31:0] word;
    logic [31:0] res;
    logic        ale;
    logic        ll;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  vec_t vq[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_sram_rsp_if if1 ();
  data_sram_rsp_if if2 ();

  data_sram_rsp #(.ADDR_W(10), .RD_LAT(1)) u_dut1 (.clk(clk), .resetn(resetn), .bus(if1));
  data_sram_rsp #(.ADDR_W(10), .RD_LAT(2)) u_dut2 (.clk(clk), .resetn(resetn), .bus(if2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [5:0] op,
                       input logic [4:0] dest, input logic fl);
    if1.data_sram_en = en;   if2.data_sram_en = en;
    if1.data_sram_we = we;   if2.data_sram_we = we;
    if1.data_sram_addr = addr;   if2.data_sram_addr = addr;
    if1.data_sram_wdata = wdata; if2.data_sram_wdata = wdata;
    if1.req_load_op = op;    if2.req_load_op = op;
    if1.req_dest = dest;     if2.req_dest = dest;
    if1.flush = fl;          if2.flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 32'h0, 32'h0, OP_NONE, 5'd0, 1'b0);
  endtask

  // Called right after driving a load; the launch edge is the next one.
  task automatic push_exp(input logic [4:0] dest, input logic [31:0] word,
                          input logic [31:0] res, input logic ale, input logic ll,
                          input bit to1, input bit to2);
    exp_t e;
    e.dest = dest; e.word = word; e.res = res; e.ale = ale; e.ll = ll;
    if (to1) begin e.due = cyc + 1; q1.push_back(e); end
    if (to2) begin e.due = cyc + 2; q2.push_back(e); end
  endtask

  task automatic add(input logic en, input logic [3:0] we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [5:0] op, input logic [4:0] dest,
                     input logic [31:0] word, input logic [31:0] res, input logic ale);
    vec_t v;
    v.en = en; v.we = we; v.addr = addr; v.wdata = wdata; v.op = op;
    v.dest = dest; v.word = word; v.res = res; v.ale = ale;
    vq.push_back(v);
  endtask

  task automatic mon(input int id, input logic v, input logic [4:0] d, input logic [31:0] w,
                     input logic [31:0] r, input logic ale, input logic ll);
    exp_t e;
    bit   have;
    have = (id == 1) ? (q1.size() != 0) : (q2.size() != 0);
    if (have) begin
      if (id == 1) e = q1[0];
      else         e = q2[0];
    end
    if (v) begin
      check($sformatf("dut%0d rsp_expected", id), {31'd0, have}, 32'd1);
      if (have) begin
        if (id == 1) void'(q1.pop_front());
        else         void'(q2.pop_front());
        check($sformatf("dut%0d rsp_cycle d%0d", id, e.dest), cyc, e.due);
        check($sformatf("dut%0d rsp_dest", id), {27'd0, d}, {27'd0, e.dest});
        check($sformatf("dut%0d rsp_rdata d%0d", id, e.dest), w, e.word);
        check($sformatf("dut%0d rsp_load_result d%0d", id, e.dest), r, e.res);
        check($sformatf("dut%0d rsp_ale d%0d", id, e.dest), {31'd0, ale}, {31'd0, e.ale});
        check($sformatf("dut%0d rsp_ll d%0d", id, e.dest), {31'd0, ll}, {31'd0, e.ll});
      end
    end else begin
      check($sformatf("dut%0d idle_fields", id), {25'd0, d, ale, ll}, 32'd0);
      check($sformatf("dut%0d idle_result", id), r, 32'd0);
      if (have && cyc > e.due) begin
        check($sformatf("dut%0d rsp_missing d%0d", id, e.dest), 32'd0, 32'd1);
        if (id == 1) void'(q1.pop_front());
        else         void'(q2.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    mon(1, if1.rsp_valid, if1.rsp_dest, if1.rsp_rdata, if1.rsp_load_result, if1.rsp_ale, if1.rsp_ll);
    mon(2, if2.rsp_valid, if2.rsp_dest, if2.rsp_rdata, if2.rsp_load_result, if2.rsp_ale, if2.rsp_ll);
  end

  task automatic check_all_zero(input string tag);
    check({tag, " dut1 outs"}, {25'd0, if1.rsp_dest, if1.rsp_valid, if1.rsp_ale}, 32'd0);
    check({tag, " dut1 ll"}, {31'd0, if1.rsp_ll}, 32'd0);
    check({tag, " dut1 result"}, if1.rsp_load_result, 32'd0);
    check({tag, " dut1 rdata"}, if1.rsp_rdata, 32'd0);
    check({tag, " dut2 outs"}, {25'd0, if2.rsp_dest, if2.rsp_valid, if2.rsp_ale}, 32'd0);
    check({tag, " dut2 ll"}, {31'd0, if2.rsp_ll}, 32'd0);
    check({tag, " dut2 result"}, if2.rsp_load_result, 32'd0);
  endtask

  initial begin
    // ---------------- vector table ----------------
    add(1, 4'hF, 32'h100,  32'h12345678, OP_NONE, 0,  0, 0, 0);
    add(1, 4'h0, 32'h100,  0, OP_LDW,  7,  32'h12345678, 32'h12345678, 0);
    add(1, 4'h2, 32'h101,  32'hABABABAB, OP_NONE, 0,  0, 0, 0);
    add(1, 4'h0, 32'h100,  0, OP_LDW,  1,  32'h1234AB78, 32'h1234AB78, 0);
    add(1, 4'h0, 32'h101,  0, OP_LDB,  2,  32'h1234AB78, 32'hFFFFFFAB, 0);
    add(1, 4'h0, 32'h101,  0, OP_LDBU, 3,  32'h1234AB78, 32'h000000AB, 0);
    add(1, 4'h0, 32'h102,  0, OP_LDH,  4,  32'h1234AB78, 32'h00001234, 0);
    add(1, 4'h0, 32'h101,  0, OP_LDH,  5,  32'h1234AB78, 32'h00000000, 1);
    add(1, 4'h0, 32'h100,  0, OP_LLW,  6,  32'h1234AB78, 32'h1234AB78, 0);
    add(1, 4'h0, 32'h100,  0, OP_LDHU, 8,  32'h1234AB78, 32'h0000AB78, 0);
    add(1, 4'h0, 32'h100,  0, OP_LDH,  9,  32'h1234AB78, 32'hFFFFAB78, 0);
    add(1, 4'h0, 32'h100,  0, OP_LDB,  10, 32'h1234AB78, 32'h00000078, 0);
    add(1, 4'h0, 32'h102,  0, OP_LDW,  11, 32'h1234AB78, 32'h00000000, 1);
    add(1, 4'h0, 32'h103,  0, OP_LDBU, 12, 32'h1234AB78, 32'h00000012, 0);
    add(1, 4'h0, 32'h103,  0, OP_LDHU, 24, 32'h1234AB78, 32'h00000000, 1);
    add(1, 4'hF, 32'h1000, 32'hCAFEF00D, OP_NONE, 0,  0, 0, 0);
    add(1, 4'h0, 32'h0,    0, OP_LDW,  13, 32'hCAFEF00D, 32'hCAFEF00D, 0);
    add(1, 4'hF, 32'h200,  32'h11112222, OP_NONE, 0,  0, 0, 0);
    add(1, 4'hC, 32'h202,  32'h80018001, OP_NONE, 0,  0, 0, 0);
    add(1, 4'h0, 32'h202,  0, OP_LDH,  14, 32'h80012222, 32'hFFFF8001, 0);
    add(1, 4'h0, 32'h202,  0, OP_LDHU, 15, 32'h80012222, 32'h00008001, 0);
    add(1, 4'h0, 32'h203,  0, OP_LDB,  16, 32'h80012222, 32'hFFFFFF80, 0);
    add(1, 4'h0, 32'h200,  0, OP_LDHU, 17, 32'h80012222, 32'h00002222, 0);
    add(1, 4'h0, 32'h100,  0, OP_NONE, 26, 0, 0, 0);                     // no-op
    add(1, 4'hF, 32'h300,  32'h55AA55AA, OP_LDW, 18, 0, 0, 0);           // write wins
    add(1, 4'h0, 32'h300,  0, OP_LDW,  19, 32'h55AA55AA, 32'h55AA55AA, 0);
    add(0, 4'hF, 32'h100,  32'h00000000, OP_LDW, 27, 0, 0, 0);           // en=0
    add(1, 4'h0, 32'h1100, 0, OP_LDW,  25, 32'h1234AB78, 32'h1234AB78, 0);

    // ---------------- reset state ----------------
    idle();
    #3;
    check_all_zero("reset_state");
    step();
    step();
    resetn = 1'b1;

    // ---------------- table-driven traffic ----------------
    foreach (vq[i]) begin
      step();
      drive(vq[i].en, vq[i].we, vq[i].addr, vq[i].wdata, vq[i].op, vq[i].dest, 1'b0);
      if (vq[i].en && vq[i].we == 4'h0 && vq[i].op != OP_NONE)
        push_exp(vq[i].dest, vq[i].word, vq[i].res, vq[i].ale, vq[i].op == OP_LLW, 1, 1);
    end
    step();
    idle();
    repeat (3) step();

    // ---------------- flush ----------------
    // The RD_LAT=1 responder has already answered before the flush edge.
    drive(1, 4'h0, 32'h100, 0, OP_LDW, 20, 1'b0);
    push_exp(20, 32'h1234AB78, 32'h1234AB78, 0, 0, 1, 0);
    step();
    drive(1, 4'hF, 32'h100, 32'hDEADBEEF, OP_NONE, 0, 1'b1);
    step();
    drive(1, 4'h0, 32'h100, 0, OP_LDW, 21, 1'b0);
    push_exp(21, 32'h1234AB78, 32'h1234AB78, 0, 0, 1, 1);
    step();
    idle();
    repeat (3) step();

    // ---------------- reset mid-operation ----------------
    drive(1, 4'h0, 32'h100, 0, OP_LDW, 22, 1'b0);
    step();
    idle();
    check("pre_reset dut1 rsp_valid", {31'd0, if1.rsp_valid}, 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    check_all_zero("async_reset");
    drive(1, 4'hF, 32'h100, 32'hFFFFFFFF, OP_NONE, 0, 1'b0);   // ignored in reset
    step();
    step();
    idle();
    resetn = 1'b1;
    repeat (4) step();
    drive(1, 4'h0, 32'h100, 0, OP_LDW, 23, 1'b0);
    push_exp(23, 32'h1234AB78, 32'h1234AB78, 0, 0, 1, 1);
    step();
    idle();

    // ---------------- drain ----------------
    repeat (5) step();
    check("dut1 queue_drained", q1.size(), 32'd0);
    check("dut2 queue_drained", q2.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
